// File: rtl/fp_pkg.sv
// Shared definitions for the FP multiply stage of the inverse-square-root
// pipeline: float field widths, exponent bias, accepted exponent window,
// the multiply-stage FSM encoding and a small field-classification helper.
package fp_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int FLOAT_W  = 31;
  localparam int PROD_W   = 48;
  localparam int SIG_W    = MANT_W + 1;   // mantissa with hidden one

  // Unbiased exponent sum is kept 10 bits wide so the full range
  // (-254 .. +256) fits before the window check.
  localparam int SUM_W = 10;
  localparam logic signed [SUM_W-1:0] EXP_SUM_OFS = SUM_W'(2 * EXP_BIAS);
  localparam logic signed [SUM_W-1:0] EXP_SUM_MAX = SUM_W'(EXP_BIAS - 1);
  localparam logic signed [SUM_W-1:0] EXP_SUM_MIN = -SUM_W'(EXP_BIAS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Zero (denormal/zero) and all-ones (inf/NaN) exponents are not handled
  // by this pipeline and are flagged as errors.
  function automatic logic exp_special(input logic [EXP_W-1:0] e);
    return (e == '0) || (e == '1);
  endfunction

endpackage

// File: rtl/fp_mul_iter_core.sv
// Iterative shift-add mantissa multiplier.
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   load_i      latch new significands, clear accumulator and counter
//   step_i      perform one BPC-bit iteration
//   sig_a_i     multiplicand {1, mantA}
//   sig_b_i     multiplier   {1, mantB}
//   acc_next_o  accumulator value after the current step (combinational)
//   last_o      the current step is the final one of the operation
// The multiplicand is shifted left each step so the accumulator always
// holds the partial product in final bit position.
module fp_mul_iter_core
  import fp_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [SIG_W-1:0]  sig_a_i,
  input  logic [SIG_W-1:0]  sig_b_i,
  output logic [PROD_W-1:0] acc_next_o,
  output logic              last_o
);

  localparam int N     = SIG_W / BPC;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  logic [PROD_W-1:0] acc_q, mcand_q;
  logic [SIG_W-1:0]  mplier_q;
  logic [CNT_W-1:0]  cnt_q;

  // One partial product per multiplier bit consumed this step.
  logic [PROD_W-1:0] pp [BPC];
  logic [PROD_W-1:0] psum;

  genvar gi;
  generate
    for (gi = 0; gi < BPC; gi++) begin : g_pp
      assign pp[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
    end
  endgenerate

  always_comb begin
    psum = '0;
    for (int i = 0; i < BPC; i++) begin
      psum = psum + pp[i];
    end
    acc_next_o = acc_q + psum;
  end

  assign last_o = (cnt_q == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      acc_q    <= '0;
      mcand_q  <= {{(PROD_W - SIG_W){1'b0}}, sig_a_i};
      mplier_q <= sig_b_i;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q    <= acc_next_o;
      mcand_q  <= mcand_q << BPC;
      mplier_q <= mplier_q >> BPC;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/fp_mul_mantissa_iter.sv
// FP multiply stage: unpacks two sign-less 31-bit floats, forms the exact
// 48-bit significand product iteratively (BPC bits per cycle), the unbiased
// exponent sum and an error flag, and forwards a sideband operand.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   valid, accept    upstream handshake (transfer = valid & accept)
//   float_in_1/2     operands {exp[30:23], mant[22:0]}
//   float_in_pass    sideband carried to float_out_2
//   error_in         upstream error flag
//   backprn          downstream can take the result (0 = hold outputs)
//   M_out_mul        raw product {1,mantA} x {1,mantB}
//   E_out_mul        unbiased exponent sum (low 8 bits)
//   float_out_2      registered sideband
//   ready, error_out result valid and its error flag
module fp_mul_mantissa_iter
  import fp_pkg::*;
#(
  parameter int BPC = 1   // legal: 1,2,3,4,6,8,12,24
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     valid,
  input  logic [FLOAT_W-1:0]       float_in_1,
  input  logic [FLOAT_W-1:0]       float_in_2,
  input  logic [FLOAT_W-1:0]       float_in_pass,
  input  logic                     error_in,
  output logic                     accept,
  input  logic                     backprn,
  output logic [PROD_W-1:0]        M_out_mul,
  output logic signed [EXP_W-1:0]  E_out_mul,
  output logic [FLOAT_W-1:0]       float_out_2,
  output logic                     ready,
  output logic                     error_out
);

  state_e state_q, state_d;

  logic load, step, last;
  logic [PROD_W-1:0] acc_next;

  logic [EXP_W-1:0] exp_a, exp_b;
  logic signed [SUM_W-1:0] sum_d;
  logic err_d;

  logic signed [EXP_W-1:0] e_q;
  logic                    err_q;
  logic [FLOAT_W-1:0]      side_q;

  logic [PROD_W-1:0]       m_out_q;
  logic signed [EXP_W-1:0] e_out_q;
  logic [FLOAT_W-1:0]      f2_out_q;
  logic                    ready_q, err_out_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid) state_d = MUL;
      MUL:     if (last)  state_d = DONE;
      DONE:    if (backprn) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept = (state_q == IDLE);
    step   = (state_q == MUL);
    load   = valid & accept;
  end

  // ---------------- exponent / error ----------------
  assign exp_a = float_in_1[MANT_W +: EXP_W];
  assign exp_b = float_in_2[MANT_W +: EXP_W];
  assign sum_d = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - EXP_SUM_OFS;
  assign err_d = error_in | exp_special(exp_a) | exp_special(exp_b)
               | (sum_d > EXP_SUM_MAX) | (sum_d < EXP_SUM_MIN);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      e_q    <= '0;
      err_q  <= 1'b0;
      side_q <= '0;
    end else if (load) begin
      e_q    <= sum_d[EXP_W-1:0];
      err_q  <= err_d;
      side_q <= float_in_pass;
    end
  end

  // ---------------- mantissa datapath ----------------
  fp_mul_iter_core #(.BPC(BPC)) u_core (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (load),
    .step_i     (step),
    .sig_a_i    ({1'b1, float_in_1[MANT_W-1:0]}),
    .sig_b_i    ({1'b1, float_in_2[MANT_W-1:0]}),
    .acc_next_o (acc_next),
    .last_o     (last)
  );

  // ---------------- output registers ----------------
  // Results are captured on the same edge as the final iteration, so the
  // product comes straight from the accumulator's next value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_out_q   <= '0;
      e_out_q   <= '0;
      f2_out_q  <= '0;
      ready_q   <= 1'b0;
      err_out_q <= 1'b0;
    end else if (step && last) begin
      m_out_q   <= acc_next;
      e_out_q   <= e_q;
      f2_out_q  <= side_q;
      ready_q   <= 1'b1;
      err_out_q <= err_q;
    end else if ((state_q == DONE) && backprn) begin
      // Data outputs keep their last values after the transfer.
      ready_q   <= 1'b0;
      err_out_q <= 1'b0;
    end
  end

  assign M_out_mul   = m_out_q;
  assign E_out_mul   = e_out_q;
  assign float_out_2 = f2_out_q;
  assign ready       = ready_q;
  assign error_out   = err_out_q;

endmodule

// File: tb/tb_fp_mul_mantissa_iter.sv
module tb_fp_mul_mantissa_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: BPC=1 (N=24), index 1: BPC=4 (N=6)
  logic [1:0]        rstn, valid, error_in, backprn, accept, ready, error_out;
  logic [1:0][30:0]  fa, fb, fp, f2;
  logic [1:0][47:0]  m;
  logic [1:0][7:0]   e;

  logic [47:0] exp_m  [2];
  logic [7:0]  exp_e  [2];
  logic [30:0] exp_f2 [2];
  logic        exp_er [2];
  logic [1:0]  exp_on;

  int tests = 0;
  int fails = 0;

  fp_mul_mantissa_iter #(.BPC(1)) dut0 (
    .clk(clk), .rstn(rstn[0]), .valid(valid[0]),
    .float_in_1(fa[0]), .float_in_2(fb[0]), .float_in_pass(fp[0]),
    .error_in(error_in[0]), .accept(accept[0]), .backprn(backprn[0]),
    .M_out_mul(m[0]), .E_out_mul(e[0]), .float_out_2(f2[0]),
    .ready(ready[0]), .error_out(error_out[0])
  );

  fp_mul_mantissa_iter #(.BPC(4)) dut1 (
    .clk(clk), .rstn(rstn[1]), .valid(valid[1]),
    .float_in_1(fa[1]), .float_in_2(fb[1]), .float_in_pass(fp[1]),
    .error_in(error_in[1]), .accept(accept[1]), .backprn(backprn[1]),
    .M_out_mul(m[1]), .E_out_mul(e[1]), .float_out_2(f2[1]),
    .ready(ready[1]), .error_out(error_out[1])
  );

  function automatic int n_of(input int d);
    return (d == 0) ? 24 : 6;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: exact significand product, unbiased exponent sum, error rules.
  function automatic void model(input logic [30:0] a, input logic [30:0] b, input logic ei,
                                output logic [47:0] mm, output logic [7:0] ee, output logic er);
    int ea, eb, s;
    logic [47:0] sa, sb;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = ea + eb - 254;
    sa = {24'h0, 1'b1, a[22:0]};
    sb = {24'h0, 1'b1, b[22:0]};
    mm = sa * sb;
    ee = 8'(s);
    er = ei || ea == 0 || ea == 255 || eb == 0 || eb == 255 || s > 126 || s < -126;
  endfunction

  // Per-cycle comparison against the model whenever a result is presented.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ready[d]) begin
        if (!exp_on[d]) begin
          check("spurious_ready", {63'h0, ready[d]}, 64'h0);
        end else begin
          check("M_out_mul", {16'h0, m[d]}, {16'h0, exp_m[d]});
          check("E_out_mul", {56'h0, e[d]}, {56'h0, exp_e[d]});
          check("float_out_2", {33'h0, f2[d]}, {33'h0, exp_f2[d]});
          check("error_out", {63'h0, error_out[d]}, {63'h0, exp_er[d]});
        end
      end else begin
        check("error_out_idle", {63'h0, error_out[d]}, 64'h0);
      end
    end
  end

  // Present operands, wait for acceptance, then wait for ready and check latency.
  task automatic run_op(input int d, input logic [30:0] a, input logic [30:0] b,
                        input logic [30:0] p, input logic ei);
    int w;
    int edges;
    @(negedge clk);
    fa[d] = a; fb[d] = b; fp[d] = p; error_in[d] = ei;
    valid[d] = 1'b1; backprn[d] = 1'b0;
    w = 0;
    while (!accept[d] && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("accept_wait", {63'h0, accept[d]}, 64'h1);
    @(posedge clk);
    #1;
    model(a, b, ei, exp_m[d], exp_e[d], exp_er[d]);
    exp_f2[d] = p;
    exp_on[d] = 1'b1;
    valid[d]  = 1'b0;
    edges = 1;
    while (!ready[d] && edges < 100) begin
      check("accept_busy", {63'h0, accept[d]}, 64'h0);
      @(posedge clk);
      #1;
      edges++;
    end
    check("latency", 64'(edges), 64'(n_of(d) + 1));
    $display("[TB] dut%0d A=%h B=%h err_in=%0b -> M=%h E=%0d err=%0b latency=%0d",
             d, a, b, ei, m[d], $signed(e[d]), error_out[d], edges);
  endtask

  // Stall for 'hold' cycles (with new operands offered), then complete the transfer.
  task automatic release_out(input int d, input int hold);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      valid[d] = 1'b1;
      fa[d] = 31'($urandom); fb[d] = 31'($urandom); fp[d] = 31'($urandom);
      check("hold_ready", {63'h0, ready[d]}, 64'h1);
      check("hold_accept", {63'h0, accept[d]}, 64'h0);
    end
    @(negedge clk);
    backprn[d] = 1'b1;
    @(posedge clk);
    #1;
    exp_on[d]  = 1'b0;
    valid[d]   = 1'b0;
    backprn[d] = 1'b0;
    check("post_ready", {63'h0, ready[d]}, 64'h0);
    check("post_error", {63'h0, error_out[d]}, 64'h0);
    check("post_accept", {63'h0, accept[d]}, 64'h1);
    check("post_M_kept", {16'h0, m[d]}, {16'h0, exp_m[d]});
  endtask

  initial begin
    logic [30:0] ra, rb;
    logic [7:0]  xa, xb;
    int w;

    rstn = '0; valid = '0; error_in = '0; backprn = '0;
    fa = '0; fb = '0; fp = '0;
    exp_on = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", {63'h0, ready[d]}, 64'h0);
      check("rst_M", {16'h0, m[d]}, 64'h0);
      check("rst_E", {56'h0, e[d]}, 64'h0);
      check("rst_f2", {33'h0, f2[d]}, 64'h0);
    end
    @(negedge clk);
    rstn = '1;
    @(posedge clk);
    #1;
    check("rst_accept0", {63'h0, accept[0]}, 64'h1);
    check("rst_accept1", {63'h0, accept[1]}, 64'h1);

    // 1.0 x 1.0
    run_op(0, 31'h3F800000, 31'h3F800000, 31'h0, 1'b0);
    check("lit_1x1_M", {16'h0, m[0]}, 64'h4000_0000_0000);
    check("lit_1x1_E", {56'h0, e[0]}, 64'h0);
    check("lit_1x1_err", {63'h0, error_out[0]}, 64'h0);
    release_out(0, 0);

    // 2.0 x 3.0 with sideband
    run_op(0, 31'h40000000, 31'h40400000, 31'h12345678, 1'b0);
    check("lit_2x3_M", {16'h0, m[0]}, 64'h6000_0000_0000);
    check("lit_2x3_E", {56'h0, e[0]}, 64'h2);
    check("lit_2x3_f2", {33'h0, f2[0]}, 64'h12345678);
    release_out(0, 0);

    // 1.5 x 1.5 on both widths
    for (int d = 0; d < 2; d++) begin
      run_op(d, 31'h3FC00000, 31'h3FC00000, 31'h0, 1'b0);
      check("lit_15_M", {16'h0, m[d]}, 64'h9000_0000_0000);
      check("lit_15_E", {56'h0, e[d]}, 64'h0);
      release_out(d, 0);
    end

    // Error cases
    run_op(0, 31'h7F800000, 31'h3F800000, 31'h0, 1'b0);
    check("lit_err_exp255", {63'h0, error_out[0]}, 64'h1);
    release_out(0, 0);
    run_op(0, 31'h7F000000, 31'h7F000000, 31'h0, 1'b0);
    check("lit_err_ovf", {63'h0, error_out[0]}, 64'h1);
    release_out(0, 0);
    run_op(1, 31'h3F800000, 31'h3F800000, 31'h0, 1'b1);
    check("lit_err_in", {63'h0, error_out[1]}, 64'h1);
    release_out(1, 0);

    // Backpressure: held results, offered operands ignored, then a fresh op
    run_op(0, 31'h40000000, 31'h40400000, 31'h0ABCDEF0, 1'b0);
    release_out(0, 5);
    run_op(0, 31'h3FC00000, 31'h3FC00000, 31'h00000001, 1'b0);
    check("lit_bp_next_M", {16'h0, m[0]}, 64'h9000_0000_0000);
    release_out(0, 0);

    // Randomized operations
    for (int i = 0; i < 15; i++) begin
      for (int d = 0; d < 2; d++) begin
        ra = 31'($urandom);
        rb = 31'($urandom);
        if ($urandom_range(0, 7) != 0) begin
          xa = 8'($urandom_range(64, 190));
          xb = 8'($urandom_range(64, 190));
          ra[30:23] = xa;
          rb[30:23] = xb;
        end
        run_op(d, ra, rb, 31'($urandom), 1'($urandom_range(0, 7) == 0));
        release_out(d, int'($urandom_range(0, 3)));
      end
    end

    // Reset in the middle of a multiplication
    @(negedge clk);
    fa[0] = 31'h40000000; fb[0] = 31'h40400000; valid[0] = 1'b1;
    w = 0;
    while (!accept[0] && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rstn[0] = 1'b0;
    valid[0] = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_ready", {63'h0, ready[0]}, 64'h0);
    check("midrst_error", {63'h0, error_out[0]}, 64'h0);
    check("midrst_M", {16'h0, m[0]}, 64'h0);
    check("midrst_E", {56'h0, e[0]}, 64'h0);
    check("midrst_accept", {63'h0, accept[0]}, 64'h1);
    @(negedge clk);
    rstn[0] = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_no_ready", {63'h0, ready[0]}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
